// File: rtl/dsm_cic_decimator_if.sv
// Bitstream-in / PCM-out bundle of the sinc^3 decimator.
// The master side feeds qualified bits and the slave side returns strobed samples.
interface dsm_cic_decimator_if #(
  parameter int W = 20
);
  logic                bit_valid;
  logic                bit_in;
  logic signed [W-1:0] sample_out;
  logic                sample_valid;
  logic                settled;

  modport master (
    output bit_valid,
    output bit_in,
    input  sample_out,
    input  sample_valid,
    input  settled
  );

  modport slave (
    input  bit_valid,
    input  bit_in,
    output sample_out,
    output sample_valid,
    output settled
  );
endinterface

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator that rebuilds signed PCM samples from a 1-bit PDM stream.
// Integrators run on accepted bits, and the combs run once per R bits on the decimated word.
module dsm_cic_decimator #(
  parameter int DEC_LOG2 = 6,
  parameter int ORDER    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  dsm_cic_decimator_if.slave    bus
);
  localparam int W = ORDER * DEC_LOG2 + 2;

  generate
    if (ORDER != 3) begin : g_order_check
      $error("dsm_cic_decimator supports ORDER == 3 only");
    end
  endgenerate

  logic signed [W-1:0]   x;
  logic signed [W-1:0]   integ_reg  [ORDER];
  logic signed [W-1:0]   integ_next [ORDER];
  logic signed [W-1:0]   delay_reg  [ORDER];
  logic signed [W-1:0]   comb_in    [ORDER];
  logic signed [W-1:0]   comb_out   [ORDER];
  logic [DEC_LOG2-1:0]   phase_reg;
  logic signed [W-1:0]   dec_reg;
  logic                  dec_stb_reg;
  logic signed [W-1:0]   sample_reg;
  logic                  valid_reg;
  logic [1:0]            settle_reg;
  logic                  tick;

  // A 1 bit maps to +1 and a 0 bit maps to -1. All-ones is -1 in W-bit two's complement.
  assign x    = bus.bit_in ? W'(1) : '1;
  assign tick = bus.bit_valid && (&phase_reg);

  // Each integrator sums the previous stage's *old* value, which gives one register delay per stage.
  genvar gi;
  generate
    for (gi = 0; gi < ORDER; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign integ_next[gi] = integ_reg[gi] + x;
        assign comb_in[gi]    = dec_reg;
      end else begin : g_rest
        assign integ_next[gi] = integ_reg[gi] + integ_reg[gi-1];
        assign comb_in[gi]    = comb_out[gi-1];
      end
      assign comb_out[gi] = comb_in[gi] - delay_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ORDER; i++) begin
        integ_reg[i] <= '0;
      end
      phase_reg   <= '0;
      dec_reg     <= '0;
      dec_stb_reg <= 1'b0;
    end else begin
      if (bus.bit_valid) begin
        for (int i = 0; i < ORDER; i++) begin
          integ_reg[i] <= integ_next[i];
        end
        phase_reg <= phase_reg + 1'b1;
      end
      if (tick) begin
        dec_reg <= integ_next[ORDER-1];
      end
      dec_stb_reg <= tick;
    end
  end

  // The comb stage fires on the decimated strobe, independent of the bit qualifier.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ORDER; i++) begin
        delay_reg[i] <= '0;
      end
      sample_reg <= '0;
      valid_reg  <= 1'b0;
      settle_reg <= '0;
    end else begin
      valid_reg <= dec_stb_reg;
      if (dec_stb_reg) begin
        for (int i = 0; i < ORDER; i++) begin
          delay_reg[i] <= comb_in[i];
        end
        sample_reg <= comb_out[ORDER-1];
        // The counter advances on the same edge that raises sample_valid, so settled aligns with the 3rd strobe.
        if (settle_reg != 2'd3) begin
          settle_reg <= settle_reg + 2'd1;
        end
      end
    end
  end

  assign bus.sample_out   = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.settled      = (settle_reg == 2'd3);
endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Randomised and directed bench for the sinc^3 decimator, checked against a direct-convolution model.
// The model convolves the accepted +/-1 stream with the sinc^3 impulse response of length 3R-2.
module tb_dsm_cic_decimator;
  localparam int R  = 64;
  localparam int HL = 3 * R - 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dsm_cic_decimator_if #(.W(20)) ifc();

  dsm_cic_decimator #(.DEC_LOG2(6), .ORDER(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          h [HL];
  int          xs [$];
  int          n_samp = 0;
  int          cyc = 0;
  bit          pend = 0;
  logic [19:0] pend_val = '0;
  logic        exp_sv = 1'b0;
  logic        exp_settled = 1'b0;
  logic [19:0] exp_out = '0;

  task automatic init_model();
    int h1 [R];
    int h2 [2*R-1];
    for (int i = 0; i < R; i++) h1[i] = 1;
    for (int i = 0; i < 2*R-1; i++) h2[i] = 0;
    for (int i = 0; i < HL; i++) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) h2[i+j] += h1[i] * h1[j];
    for (int i = 0; i < 2*R-1; i++)
      for (int j = 0; j < R; j++) h[i+j] += h2[i] * h1[j];
  endtask

  // Sample k (1-based) is produced after bit k*R and sees the stream through a two-bit integrator delay.
  function automatic int model_sample(int k);
    int acc = 0;
    for (int j = 0; j < HL; j++) begin
      int idx = k * R - 3 - j;
      if (idx >= 0) acc += h[j] * xs[idx];
    end
    return acc;
  endfunction

  task automatic step(input logic r, input logic v, input logic b);
    reset = r;
    ifc.bit_valid = v;
    ifc.bit_in = b;
    @(posedge clock);
    #1;
    cyc++;
    if (r) begin
      xs.delete();
      pend = 0;
      n_samp = 0;
      exp_sv = 1'b0;
      exp_out = '0;
      exp_settled = 1'b0;
    end else begin
      exp_sv = pend;
      if (pend) begin
        n_samp++;
        exp_out = pend_val;
        if (n_samp >= 3) exp_settled = 1'b1;
        $display("sample %0d cyc %0d out %0d expected %0d settled %b",
                 n_samp, cyc, ifc.sample_out, $signed(exp_out), ifc.settled);
      end
      pend = 0;
      if (v) begin
        xs.push_back(b ? 1 : -1);
        if (xs.size() % R == 0) begin
          pend = 1;
          pend_val = 20'(model_sample(xs.size() / R));
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(1, 1, 1);
      n_vec++; if (ifc.sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", ifc.sample_valid); end
      n_vec++; if (ifc.sample_out !== 20'd0) begin n_bad++; $display("FAIL reset_out got=%0d want=0", ifc.sample_out); end
      n_vec++; if (ifc.settled !== 1'b0) begin n_bad++; $display("FAIL reset_settled got=%b want=0", ifc.settled); end
    end
  endtask

  task automatic test_dc_level(input logic b, input logic [19:0] steady);
    int last = -1;
    step(1, 0, 0);
    for (int c = 0; c < 5 * R + 2; c++) begin
      step(0, 1, b);
      n_vec++; if (ifc.sample_valid !== exp_sv) begin n_bad++; $display("FAIL dc_valid b=%b cyc=%0d got=%b want=%b", b, cyc, ifc.sample_valid, exp_sv); end
      n_vec++; if (ifc.sample_out !== exp_out) begin n_bad++; $display("FAIL dc_out b=%b cyc=%0d got=%0d want=%0d", b, cyc, ifc.sample_out, $signed(exp_out)); end
      n_vec++; if (ifc.settled !== exp_settled) begin n_bad++; $display("FAIL dc_settled b=%b cyc=%0d got=%b want=%b", b, cyc, ifc.settled, exp_settled); end
      if (exp_sv && n_samp >= 3) begin
        n_vec++; if (ifc.sample_out !== steady) begin n_bad++; $display("FAIL dc_steady b=%b got=%0d want=%0d", b, ifc.sample_out, $signed(steady)); end
      end
      if (ifc.sample_valid === 1'b1) begin
        if (last >= 0) begin
          n_vec++; if (cyc - last != R) begin n_bad++; $display("FAIL dc_spacing got=%0d want=%0d", cyc - last, R); end
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_alternating();
    step(1, 0, 0);
    for (int c = 0; c < 5 * R + 2; c++) begin
      step(0, 1, (c % 2) == 0);
      n_vec++; if (ifc.sample_valid !== exp_sv) begin n_bad++; $display("FAIL alt_valid cyc=%0d got=%b want=%b", cyc, ifc.sample_valid, exp_sv); end
      n_vec++; if (ifc.sample_out !== exp_out) begin n_bad++; $display("FAIL alt_out cyc=%0d got=%0d want=%0d", cyc, ifc.sample_out, $signed(exp_out)); end
      if (exp_sv && n_samp >= 3) begin
        n_vec++; if (ifc.sample_out !== 20'd0) begin n_bad++; $display("FAIL alt_zero got=%0d want=0", ifc.sample_out); end
      end
    end
  endtask

  task automatic test_three_quarter();
    step(1, 0, 0);
    for (int c = 0; c < 9 * R + 2; c++) begin
      logic b;
      b = (c < 5 * R) ? ((c % 4) != 3) : 1'b0;
      step(0, 1, b);
      n_vec++; if (ifc.sample_valid !== exp_sv) begin n_bad++; $display("FAIL tq_valid cyc=%0d got=%b want=%b", cyc, ifc.sample_valid, exp_sv); end
      n_vec++; if (ifc.sample_out !== exp_out) begin n_bad++; $display("FAIL tq_out cyc=%0d got=%0d want=%0d", cyc, ifc.sample_out, $signed(exp_out)); end
      n_vec++; if (ifc.settled !== exp_settled) begin n_bad++; $display("FAIL tq_settled cyc=%0d got=%b want=%b", cyc, ifc.settled, exp_settled); end
      if (exp_sv && n_samp >= 3 && n_samp <= 5) begin
        n_vec++; if (ifc.sample_out !== 20'h20000) begin n_bad++; $display("FAIL tq_half got=%0d want=131072", ifc.sample_out); end
      end
      if (exp_sv && n_samp >= 8) begin
        n_vec++; if (ifc.sample_out !== 20'hC0000) begin n_bad++; $display("FAIL tq_low got=%0d want=-262144", ifc.sample_out); end
      end
    end
  endtask

  task automatic test_gated_valid();
    int last = -1;
    step(1, 0, 0);
    for (int c = 0; c < 8 * R + 4; c++) begin
      step(0, (c % 2) == 0, 1'b1);
      n_vec++; if (ifc.sample_valid !== exp_sv) begin n_bad++; $display("FAIL gate_valid cyc=%0d got=%b want=%b", cyc, ifc.sample_valid, exp_sv); end
      n_vec++; if (ifc.sample_out !== exp_out) begin n_bad++; $display("FAIL gate_out cyc=%0d got=%0d want=%0d", cyc, ifc.sample_out, $signed(exp_out)); end
      if (exp_sv && n_samp >= 3) begin
        n_vec++; if (ifc.sample_out !== 20'h40000) begin n_bad++; $display("FAIL gate_steady got=%0d want=262144", ifc.sample_out); end
      end
      if (ifc.sample_valid === 1'b1) begin
        if (last >= 0) begin
          n_vec++; if (cyc - last != 2 * R) begin n_bad++; $display("FAIL gate_spacing got=%0d want=%0d", cyc - last, 2 * R); end
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_mid_reset();
    int first = -1;
    step(1, 0, 0);
    for (int c = 0; c < R + 40; c++) step(0, 1, 1'b1);
    step(1, 1, 1'b1);
    n_vec++; if (ifc.sample_out !== 20'd0 || ifc.settled !== 1'b0) begin n_bad++; $display("FAIL mid_clear out=%0d settled=%b want=0/0", ifc.sample_out, ifc.settled); end
    for (int c = 1; c <= 3 * R + 2; c++) begin
      step(0, 1, 1'b1);
      n_vec++; if (ifc.sample_valid !== exp_sv) begin n_bad++; $display("FAIL mid_valid cyc=%0d got=%b want=%b", cyc, ifc.sample_valid, exp_sv); end
      n_vec++; if (ifc.sample_out !== exp_out) begin n_bad++; $display("FAIL mid_out cyc=%0d got=%0d want=%0d", cyc, ifc.sample_out, $signed(exp_out)); end
      n_vec++; if (ifc.settled !== exp_settled) begin n_bad++; $display("FAIL mid_settled cyc=%0d got=%b want=%b", cyc, ifc.settled, exp_settled); end
      if (first < 0 && ifc.sample_valid === 1'b1) first = c;
    end
    n_vec++; if (first != R + 1) begin n_bad++; $display("FAIL mid_first_strobe got=%0d want=%0d", first, R + 1); end
    // Reset on the decimation edge, then reset while the decimated strobe is pending.
    step(1, 0, 0);
    for (int c = 0; c < R - 1; c++) step(0, 1, 1'b1);
    step(1, 1, 1'b1);
    step(0, 0, 1'b0);
    n_vec++; if (ifc.sample_valid !== 1'b0) begin n_bad++; $display("FAIL tick_reset_valid got=%b want=0", ifc.sample_valid); end
    for (int c = 0; c < R; c++) step(0, 1, 1'b1);
    step(1, 0, 0);
    n_vec++; if (ifc.sample_valid !== 1'b0) begin n_bad++; $display("FAIL stb_reset_valid got=%b want=0", ifc.sample_valid); end
    step(0, 0, 0);
    n_vec++; if (ifc.sample_valid !== 1'b0 || ifc.sample_out !== 20'd0) begin n_bad++; $display("FAIL stb_reset_after valid=%b out=%0d want=0/0", ifc.sample_valid, ifc.sample_out); end
  endtask

  task automatic test_random();
    int p = 50;
    step(1, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      if (c % 150 == 0) p = $urandom_range(0, 100);
      step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < p);
      n_vec++; if (ifc.sample_valid !== exp_sv) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, ifc.sample_valid, exp_sv); end
      n_vec++; if (ifc.sample_out !== exp_out) begin n_bad++; $display("FAIL rnd_out cyc=%0d got=%0d want=%0d", cyc, ifc.sample_out, $signed(exp_out)); end
      n_vec++; if (ifc.settled !== exp_settled) begin n_bad++; $display("FAIL rnd_settled cyc=%0d got=%b want=%b", cyc, ifc.settled, exp_settled); end
    end
  endtask

  initial begin
    ifc.bit_valid = 1'b0;
    ifc.bit_in = 1'b0;
    init_model();
    test_reset();
    test_dc_level(1'b1, 20'h40000);
    test_dc_level(1'b0, 20'hC0000);
    test_alternating();
    test_three_quarter();
    test_gated_valid();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
